// File: rtl/arch_map_table_if.sv
// Purpose: bundles the retire-to-AMT write channels, the rollback flag and the
//          committed map read-out between the retire stage and arch_map_table.
// Ports  : dp_amt_i   - C_RT_NUM packed channels {rd, tag, wr_en}, ch0 = oldest
//          rollback_i - mispredict rollback in progress (informational)
//          amt_o      - committed tag of every arch reg, entry i at [i]
// Modports: master = retire stage / consumer side, slave = map table side.
interface arch_map_table_if #(
  parameter int C_RT_NUM       = 2,
  parameter int C_ARCH_REG_NUM = 32,
  parameter int C_PHY_REG_NUM  = 64
);
  localparam int C_TAG_W      = $clog2(C_PHY_REG_NUM);
  localparam int C_ARCH_IDX_W = $clog2(C_ARCH_REG_NUM);
  localparam int C_CH_W       = C_ARCH_IDX_W + C_TAG_W + 1;

  logic [C_RT_NUM-1:0][C_CH_W-1:0]        dp_amt_i;
  logic                                   rollback_i;
  logic [C_ARCH_REG_NUM-1:0][C_TAG_W-1:0] amt_o;

  modport master (
    output dp_amt_i,
    output rollback_i,
    input  amt_o
  );

  modport slave (
    input  dp_amt_i,
    input  rollback_i,
    output amt_o
  );
endinterface

// File: rtl/arch_map_table.sv
// Purpose     : architectural (retirement) map table, committed arch->phys mapping.
// Latency     : 1 cycle from a retire write to the new value on amt_o.
// Backpressure: none; every retire write is accepted unconditionally.
//
// Ports:
//   clk_i  - clock, state updates on rising edge
//   rst_i  - asynchronous active-low reset
//   amt_if - arch_map_table_if.slave: dp_amt_i (write channels), rollback_i,
//            amt_o (flopped map contents, no write bypass)
// Configuration:
//   AMT_IDENTITY_RESET_EN - when defined, reset loads entry i with tag i
//   (requires C_PHY_REG_NUM >= C_ARCH_REG_NUM); otherwise every entry resets
//   to tag 0. Entry 0 is a hardwired zero register in both builds.
module arch_map_table #(
  parameter int C_RT_NUM       = 2,
  parameter int C_ARCH_REG_NUM = 32,
  parameter int C_PHY_REG_NUM  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  arch_map_table_if.slave   amt_if
);
  localparam int C_TAG_W      = $clog2(C_PHY_REG_NUM);
  localparam int C_ARCH_IDX_W = $clog2(C_ARCH_REG_NUM);
  localparam int C_CH_W       = C_ARCH_IDX_W + C_TAG_W + 1;

  // Unpacked channel fields: {rd, tag, wr_en} with wr_en in bit 0.
  logic [C_ARCH_IDX_W-1:0] ch_rd  [C_RT_NUM];
  logic [C_TAG_W-1:0]      ch_tag [C_RT_NUM];
  logic                    ch_en  [C_RT_NUM];

  for (genvar n = 0; n < C_RT_NUM; n++) begin : g_ch
    assign ch_rd[n]  = amt_if.dp_amt_i[n][C_CH_W-1 -: C_ARCH_IDX_W];
    assign ch_tag[n] = amt_if.dp_amt_i[n][C_TAG_W:1];
    assign ch_en[n]  = amt_if.dp_amt_i[n][0];
  end

  // Rollback does not change the committed map: the consumer samples amt_o
  // in the rollback cycle while that cycle's retire writes still land.
  logic unused_rollback;
  assign unused_rollback = amt_if.rollback_i;

  logic [C_TAG_W-1:0] entry [C_ARCH_REG_NUM];

  for (genvar i = 0; i < C_ARCH_REG_NUM; i++) begin : g_entry
    if (i == 0) begin : g_zero
      // Zero register: no storage, writes to rd=0 simply never match.
      assign entry[i] = '0;
    end else begin : g_reg
`ifdef AMT_IDENTITY_RESET_EN
      localparam logic [C_TAG_W-1:0] RST_VAL = C_TAG_W'(i);
`else
      localparam logic [C_TAG_W-1:0] RST_VAL = '0;
`endif
      logic [C_TAG_W-1:0] q;
      logic [C_TAG_W-1:0] nxt;

      // Channels are scanned oldest to youngest so the youngest matching
      // write overrides older ones targeting the same register.
      always_comb begin
        nxt = q;
        for (int n = 0; n < C_RT_NUM; n++) begin
          if (ch_en[n] && (ch_rd[n] == C_ARCH_IDX_W'(i))) begin
            nxt = ch_tag[n];
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          q <= RST_VAL;
        end else begin
          q <= nxt;
        end
      end

      assign entry[i] = q;
    end
  end

  always_comb begin
    amt_if.amt_o = '0;
    for (int j = 0; j < C_ARCH_REG_NUM; j++) begin
      amt_if.amt_o[j] = entry[j];
    end
  end
endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table: reset values, single/dual retire writes,
// same-rd priority, zero register, rollback, wr_en gating and async reset.
module tb_arch_map_table;
  localparam int NREG = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [5:0] exp_amt [NREG];

  arch_map_table_if #(.C_RT_NUM(2), .C_ARCH_REG_NUM(32), .C_PHY_REG_NUM(64)) ifc ();

  arch_map_table #(.C_RT_NUM(2), .C_ARCH_REG_NUM(32), .C_PHY_REG_NUM(64)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .amt_if (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input int rd, input int tag, input bit en);
    logic [4:0] r;
    logic [5:0] t;
    r = rd[4:0];
    t = tag[5:0];
    return {r, t, en};
  endfunction

  task automatic exp_reset();
    for (int i = 0; i < NREG; i++) begin
`ifdef AMT_IDENTITY_RESET_EN
      exp_amt[i] = 6'(i);
`else
      exp_amt[i] = 6'd0;
`endif
    end
  endtask

  task automatic check_entry(input string tag, input int idx, input logic [5:0] exp_v);
    checks++;
    assert (ifc.amt_o[idx] === exp_v) else begin
      failures++;
      $error("FAIL %s entry %0d: observed %0d expected %0d", tag, idx, ifc.amt_o[idx], exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREG; i++) begin
      check_entry(tag, i, exp_amt[i]);
    end
  endtask

  // Apply channel values at the falling edge, let one rising edge pass,
  // then clear the channels and sample 1 time unit after that edge.
  task automatic retire(input logic [11:0] c0, input logic [11:0] c1, input bit rb);
    @(negedge clk);
    ifc.dp_amt_i[0] = c0;
    ifc.dp_amt_i[1] = c1;
    ifc.rollback_i  = rb;
    @(posedge clk);
    #1;
    ifc.dp_amt_i   = '0;
    ifc.rollback_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    ifc.dp_amt_i   = '0;
    ifc.rollback_i = 1'b0;
    exp_reset();

    // Reset held for one cycle, released at a falling edge.
    @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("reset_release");

    // Single write.
    retire(pk(4, 12, 1), pk(0, 0, 0), 1'b0);
    exp_amt[4] = 6'd12;
    check_all("single_wr");

    // Dual write to distinct registers.
    retire(pk(4, 12, 1), pk(5, 13, 1), 1'b0);
    exp_amt[5] = 6'd13;
    check_all("dual_wr");

    // Same rd on both channels: channel 1 (youngest) wins.
    retire(pk(7, 20, 1), pk(7, 21, 1), 1'b0);
    exp_amt[7] = 6'd21;
    check_entry("conflict_r7", 7, 6'd21);
    check_all("conflict");

    // Writes to rd=0 are ignored on either channel.
    retire(pk(0, 9, 1), pk(0, 33, 1), 1'b0);
    check_entry("zero_reg", 0, 6'd0);
    check_all("zero_reg_all");

    // Rollback cycle: pre-write value visible before the edge, write lands after.
    @(negedge clk);
    ifc.dp_amt_i[0] = pk(6, 30, 1);
    ifc.dp_amt_i[1] = pk(0, 0, 0);
    ifc.rollback_i  = 1'b1;
    #1;
    check_entry("rollback_prewr", 6, 6'd0);
    @(posedge clk);
    #1;
    ifc.dp_amt_i   = '0;
    ifc.rollback_i = 1'b0;
    exp_amt[6] = 6'd30;
    check_entry("rollback_r6", 6, 6'd30);
    check_entry("rollback_r4", 4, 6'd12);
    check_entry("rollback_r5", 5, 6'd13);
    check_all("rollback_all");

    // wr_en = 0 gates both channels even with live rd/tag.
    retire(pk(3, 17, 0), pk(3, 18, 0), 1'b0);
    check_entry("wr_en_gate", 3, 6'd0);
    check_all("wr_en_gate_all");

    // Youngest also wins when it carries the smaller tag, and top index works.
    retire(pk(31, 63, 1), pk(31, 2, 1), 1'b0);
    exp_amt[31] = 6'd2;
    check_entry("conflict_r31", 31, 6'd2);

    // Async reset mid-cycle with a write pending: clears before the next edge.
    @(negedge clk);
    ifc.dp_amt_i[0] = pk(9, 5, 1);
    ifc.dp_amt_i[1] = pk(10, 6, 1);
    #2;
    rst = 1'b0;
    #1;
    exp_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_discards_wr");
    ifc.dp_amt_i = '0;
    @(negedge clk);
    rst = 1'b1;

    // Recovery after reset.
    retire(pk(0, 0, 0), pk(31, 63, 1), 1'b0);
    exp_amt[31] = 6'd63;
    check_all("post_reset_wr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed no completion, required finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
